// File: rtl/modcount_chain.sv
// modcount_chain: cascaded mixed-radix modulo counter.
// Digit i counts modulo MODS[i*DW +: DW]. Each digit steps only when every
// lower digit sits at its terminal value, so the whole chain behaves as one
// mixed-radix number (e.g. 0..59 with the default moduli {6,10}).
// Features: clamped parallel load, wrap/saturate at the chain terminal value,
// combinational terminal count and chain carry, sticky overflow flag.
module modcount_chain #(
    parameter int                 NDIG = 2,
    parameter int                 DW   = 4,
    parameter logic [NDIG*DW-1:0] MODS = {4'd6, 4'd10}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               up,
    input  logic               sat,
    input  logic               load,
    input  logic [NDIG*DW-1:0] din,
    input  logic               clr_ovf,
    output logic [NDIG*DW-1:0] cnt,
    output logic               nextcnt,
    output logic               tc,
    output logic               ovf
);

    // Digit arithmetic stays within DW bits; moduli are applied explicitly.
    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [NDIG-1:0]    at_term;   // digit i is at its terminal value for up
    logic [NDIG*DW-1:0] stepped;   // chain value after one count step
    logic [NDIG*DW-1:0] clamped;   // load value with every digit limited to Mi-1
    logic               term_event;

    // Per-digit terminal detect, ripple step and load clamping.
    always_comb begin
        logic [DW-1:0] digit;
        logic [DW-1:0] maxv;
        logic          lower_term;
        at_term    = '0;
        stepped    = cnt;
        clamped    = din;
        digit      = '0;
        maxv       = '0;
        lower_term = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            digit      = cnt[i*DW +: DW];
            maxv       = MODS[i*DW +: DW] - ONE;
            at_term[i] = up ? (digit == maxv) : (digit == '0);
            // Digit 0 always steps; higher digits step only when all lower
            // digits are terminal, which is what lower_term tracks.
            if (lower_term) begin
                if (at_term[i]) begin
                    stepped[i*DW +: DW] = up ? '0 : maxv;
                end else begin
                    stepped[i*DW +: DW] = up ? (digit + ONE) : (digit - ONE);
                end
            end
            lower_term = lower_term & at_term[i];
            if (din[i*DW +: DW] > maxv) begin
                clamped[i*DW +: DW] = maxv;
            end
        end
    end

    // Chain terminal count and the carry usable as the next instance's enable.
    always_comb begin
        tc         = &at_term;
        term_event = en & ~load & tc;
        nextcnt    = term_event & ~sat;
    end

    // Count register: reset > load > enable > hold; saturate holds at terminal.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= clamped;
        end else if (en) begin
            if (!(tc && sat)) begin
                cnt <= stepped;
            end
        end
    end

    // Sticky overflow: a terminal event sets it and beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (term_event) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_modcount_chain.sv
// Bench for modcount_chain with default parameters (0..59 chain).
// cnt is written as 8'hHL, i.e. {hi digit, lo digit}.
module tb_modcount_chain;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up;
    logic       sat;
    logic       load;
    logic [7:0] din;
    logic       clr_ovf;
    logic [7:0] cnt;
    logic       nextcnt;
    logic       tc;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard of registered results: {ovf, cnt}.
    logic [8:0] exp_q[$];

    typedef struct {
        logic       rst_n;
        logic       ld;
        logic       e;
        logic       u;
        logic       s;
        logic       c;
        logic [7:0] d;
        logic       etc;
        logic       enc;
        logic [7:0] ecnt;
        logic       eovf;
    } vec_t;

    vec_t vecs[$];

    // Clock and DUT
    always #5 clk = ~clk;

    modcount_chain dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up      (up),
        .sat     (sat),
        .load    (load),
        .din     (din),
        .clr_ovf (clr_ovf),
        .cnt     (cnt),
        .nextcnt (nextcnt),
        .tc      (tc),
        .ovf     (ovf)
    );

    task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Drive one cycle: comb outputs checked before the edge, registered
    // result pushed to the scoreboard and popped after the edge.
    task automatic apply(input string nm, input logic rst_n, input logic ld,
                         input logic e, input logic u, input logic s, input logic c,
                         input logic [7:0] d, input logic chk_comb,
                         input logic etc, input logic enc,
                         input logic [7:0] ecnt, input logic eovf);
        logic [8:0] exp;
        @(negedge clk);
        reset   = rst_n;
        load    = ld;
        en      = e;
        up      = u;
        sat     = s;
        clr_ovf = c;
        din     = d;
        #1;
        if (chk_comb) begin
            check({nm, ".tc"}, {8'd0, tc}, {8'd0, etc});
            check({nm, ".nextcnt"}, {8'd0, nextcnt}, {8'd0, enc});
        end
        exp_q.push_back({eovf, ecnt});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check({nm, ".cnt_ovf"}, {ovf, cnt}, exp);
    endtask

    function automatic void add(input logic rst_n, input logic ld, input logic e,
                                input logic u, input logic s, input logic c,
                                input logic [7:0] d, input logic etc, input logic enc,
                                input logic [7:0] ecnt, input logic eovf);
        vec_t v;
        v.rst_n = rst_n; v.ld = ld; v.e = e; v.u = u; v.s = s; v.c = c;
        v.d = d; v.etc = etc; v.enc = enc; v.ecnt = ecnt; v.eovf = eovf;
        vecs.push_back(v);
    endfunction

    function automatic logic [7:0] enc(input int v);
        enc = {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        int         mv;
        int         hi;
        int         lo;
        logic       mo;
        logic       r_rst;
        logic       r_ld;
        logic       r_en;
        logic       r_up;
        logic       r_sat;
        logic       r_clr;
        logic [7:0] r_din;
        logic       ttc;
        logic       tnc;

        reset = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0;
        clr_ovf = 1'b0; din = 8'h00;

        // rst ld en up sat clr din   tc nc  cnt   ovf
        add(1, 0, 1, 0, 0, 0, 8'h00, 1, 1, 8'h59, 1); // down wrap from 00
        add(1, 0, 0, 0, 0, 1, 8'h00, 0, 0, 8'h59, 0); // clr_ovf alone
        add(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h58, 0); // down step
        add(1, 1, 0, 0, 0, 0, 8'h10, 0, 0, 8'h10, 0); // load 10
        add(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h09, 0); // intermediate borrow
        add(1, 0, 1, 1, 0, 0, 8'h00, 0, 0, 8'h10, 0); // direction change, carry
        add(1, 1, 1, 1, 0, 0, 8'h7C, 0, 0, 8'h59, 0); // load {7,12} clamps
        add(1, 0, 1, 1, 1, 0, 8'h00, 1, 0, 8'h59, 1); // saturate up x3
        add(1, 0, 1, 1, 1, 0, 8'h00, 1, 0, 8'h59, 1);
        add(1, 0, 1, 1, 1, 0, 8'h00, 1, 0, 8'h59, 1);
        add(1, 0, 0, 1, 1, 1, 8'h00, 1, 0, 8'h59, 0); // tc with en=0, clear
        add(1, 1, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0); // load 00
        add(1, 0, 1, 0, 1, 0, 8'h00, 1, 0, 8'h00, 1); // saturate down x2
        add(1, 0, 1, 0, 1, 0, 8'h00, 1, 0, 8'h00, 1);
        add(1, 0, 0, 0, 0, 1, 8'h00, 1, 0, 8'h00, 0); // clear
        add(1, 1, 1, 1, 0, 0, 8'h34, 0, 0, 8'h34, 0); // load with en: no step
        for (int k = 0; k < 5; k++) begin
            add(1, 0, 0, 1, 0, 0, 8'h00, 0, 0, 8'h34, 0); // hold
        end
        add(1, 1, 0, 1, 0, 0, 8'h59, 0, 0, 8'h59, 0); // load 59
        add(1, 0, 1, 1, 0, 0, 8'h00, 1, 1, 8'h00, 1); // up wrap sets ovf
        add(1, 1, 0, 1, 0, 0, 8'h59, 0, 0, 8'h59, 1);
        add(1, 0, 1, 1, 0, 1, 8'h00, 1, 1, 8'h00, 1); // set beats clear
        add(1, 1, 0, 1, 0, 0, 8'h26, 0, 0, 8'h26, 1);
        add(1, 0, 1, 1, 0, 0, 8'h00, 0, 0, 8'h27, 1); // counting at 27
        add(0, 1, 1, 1, 0, 0, 8'h34, 0, 0, 8'h00, 0); // reset beats load/en
        add(1, 0, 1, 1, 0, 0, 8'h00, 0, 0, 8'h01, 0); // resume from 0

        // Initial reset (state before it is unknown, so no comb check)
        apply("reset", 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);

        // Up count through the full range and wrap
        for (int k = 1; k <= 60; k++) begin
            apply($sformatf("up%0d", k), 1, 0, 1, 1, 0, 0, 8'h00, 1,
                  (k == 60), (k == 60), enc(k % 60), (k == 60));
        end

        // Table vectors
        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].ld, vecs[i].e,
                  vecs[i].u, vecs[i].s, vecs[i].c, vecs[i].d, 1,
                  vecs[i].etc, vecs[i].enc, vecs[i].ecnt, vecs[i].eovf);
        end

        // Random traffic against a linear 0..59 reference
        mv = 1;
        mo = 1'b0;
        for (int k = 0; k < 400; k++) begin
            r_rst = ($urandom_range(0, 49) != 0);
            r_ld  = ($urandom_range(0, 9) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_up  = ($urandom_range(0, 1) != 0);
            r_sat = ($urandom_range(0, 3) == 0);
            r_clr = ($urandom_range(0, 7) == 0);
            r_din = 8'($urandom_range(0, 255));
            ttc   = r_up ? (mv == 59) : (mv == 0);
            tnc   = r_en && !r_ld && ttc && !r_sat;
            if (!r_rst) begin
                mv = 0;
                mo = 1'b0;
            end else if (r_ld) begin
                hi = (int'(r_din[7:4]) > 5) ? 5 : int'(r_din[7:4]);
                lo = (int'(r_din[3:0]) > 9) ? 9 : int'(r_din[3:0]);
                mv = hi * 10 + lo;
                if (r_clr) mo = 1'b0;
            end else if (r_en && ttc) begin
                mo = 1'b1;
                if (!r_sat) mv = r_up ? 0 : 59;
            end else begin
                if (r_en) mv = r_up ? mv + 1 : mv - 1;
                if (r_clr) mo = 1'b0;
            end
            apply($sformatf("rnd%0d", k), r_rst, r_ld, r_en, r_up, r_sat, r_clr,
                  r_din, 1, ttc, tnc, enc(mv), mo);
        end

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
